ram_burst_ctrl: RTL

- Initiator-side controller for the single-port-per-direction RAM macro `ram_double` (write port plus read port, active-low chip and write selects).
- Accepts burst write and burst read commands on a valid/ready interface.
- Streams write data into the RAM and returns read data on a valid stream.
- Sits between the datapath and a RAM instance clocked on the same clock; it is the requester the RAM responds to.

---
 rtl/ram_burst_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for the ram_double macro: takes write/read burst commands,
// streams write words into the RAM and returns read words two edges after issue.
module ram_burst_ctrl #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int NUMBER = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rd,
   input  logic [NUMBER-1:0] cmd_addr,
   input  logic [NUMBER-1:0] cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              rd_valid,
   output logic [WIDTH-1:0]  rd_data,
   output logic              done,
   output logic              ram_cs_n,
   output logic              ram_we_n,
   output logic [NUMBER-1:0] ram_addr_w,
   output logic [NUMBER-1:0] ram_addr_r,
   output logic [WIDTH-1:0]  ram_data_in,
   input  logic [WIDTH-1:0]  ram_data_out
);

   // state | meaning
   // IDLE  | cmd_ready high, waiting for a command
   // WRITE | wr_ready high, one RAM write per accepted word
   // READ  | one RAM read issued per cycle
   // DRAIN | RAM deselected, waiting for last write / pending reads
   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t            state;
   logic [NUMBER-1:0] cur;
   logic [NUMBER-1:0] rem;
   logic [1:0]        pend;

   function automatic logic [NUMBER-1:0] next_addr(input logic [NUMBER-1:0] a);
      return (a == NUMBER'(DEPTH - 1)) ? '0 : a + NUMBER'(1);
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cur         <= '0;
         rem         <= '0;
         pend        <= '0;
         cmd_ready   <= 1'b1;
         wr_ready    <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= '0;
         done        <= 1'b0;
         ram_cs_n    <= 1'b1;
         ram_we_n    <= 1'b1;
         ram_addr_w  <= '0;
         ram_addr_r  <= '0;
         ram_data_in <= '0;
      end else begin
         done     <= 1'b0;
         // pend[1] marks a read whose data is on ram_data_out this cycle
         pend     <= {pend[0], state == READ};
         rd_valid <= pend[1];
         if (pend[1]) begin
            rd_data <= ram_data_out;
         end

         case (state)
            IDLE: begin
               ram_cs_n <= 1'b1;
               ram_we_n <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cur       <= cmd_addr;
                  rem       <= cmd_len;
                  cmd_ready <= 1'b0;
                  if (cmd_rd) begin
                     state <= READ;
                  end else begin
                     state    <= WRITE;
                     wr_ready <= 1'b1;
                  end
               end
            end

            WRITE: begin
               if (wr_valid && wr_ready) begin
                  ram_cs_n    <= 1'b0;
                  ram_we_n    <= 1'b0;
                  ram_addr_w  <= cur;
                  ram_data_in <= wr_data;
                  cur         <= next_addr(cur);
                  rem         <= rem - NUMBER'(1);
                  if (rem == '0) begin
                     state    <= DRAIN;
                     wr_ready <= 1'b0;
                  end
               end else begin
                  ram_cs_n <= 1'b1;
                  ram_we_n <= 1'b1;
               end
            end

            READ: begin
               ram_cs_n   <= 1'b0;
               ram_we_n   <= 1'b1;
               ram_addr_r <= cur;
               cur        <= next_addr(cur);
               rem        <= rem - NUMBER'(1);
               if (rem == '0) begin
                  state <= DRAIN;
               end
            end

            DRAIN: begin
               // The last write is on the RAM pins during the first DRAIN cycle,
               // so only outstanding reads can hold completion back.
               ram_cs_n <= 1'b1;
               ram_we_n <= 1'b1;
               if (pend == 2'b00) begin
                  done      <= 1'b1;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
